// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle between the EX-stage controller (master) and alu_exec (slave)
interface alu_exec_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             err;
    logic             zero;
    logic             ovf;
    modport master (output start, alucontrol, a, b, input busy, done, result, hi, err, zero, ovf);
    modport slave (input start, alucontrol, a, b, output busy, done, result, hi, err, zero, ovf);
endinterface

// File: rtl/alu_exec.sv
// alu_exec: multi-cycle execution unit, single-cycle logic/arith, shift-add mult, restoring div (ALUEXEC_OVF_EN adds signed overflow flag)
module alu_exec #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    alu_exec_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t             state_q, state_d;
    logic [SW:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d;
    logic               err_q, err_d, zero_q, zero_d;
    logic [WIDTH-1:0]   alu_y;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0] mul_nx, div_nx;
    logic               div0;
    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
        end
    end
    // single-cycle operations straight from the live operands of the start cycle
    always_comb begin
        shamt = bus.b[SW-1:0];
        case (bus.alucontrol)
            4'b0000: alu_y = bus.a + bus.b;
            4'b0001: alu_y = bus.a - bus.b;
            4'b0100: alu_y = bus.a << shamt;
            4'b0101: alu_y = bus.a >> shamt;
            4'b0110: alu_y = bus.a & bus.b;
            4'b0111: alu_y = bus.a | bus.b;
            4'b1000: alu_y = bus.a ^ bus.b;
            4'b1001: alu_y = ~(bus.a | bus.b);
            4'b1010: alu_y = bus.a;
            4'b1011: alu_y = ~(bus.a & bus.b);
            4'b1100: alu_y = ~bus.a;
            4'b1101: alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            4'b1110: alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) > $signed(bus.b)};
            default: alu_y = '0;
        endcase
    end
    // one multiply step (add-and-shift) and one restoring divide step; the borrow bit picks restore
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_nx   = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        div_nx   = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    // next state and register updates; results only change on entry to DONE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        acc_d    = acc_q;
        result_d = result_q;
        hi_d     = hi_q;
        err_d    = err_q;
        zero_d   = zero_q;
        div0     = bus.b == '0;
        case (state_q)
            IDLE: if (bus.start) begin
                cnt_d = (SW+1)'(WIDTH);
                if (bus.alucontrol == 4'b0010) begin
                    state_d = MUL;
                    m_d     = bus.a;
                    acc_d   = {{WIDTH{1'b0}}, bus.b};
                end else if (bus.alucontrol == 4'b0011 && !div0) begin
                    state_d = DIV;
                    m_d     = bus.b;
                    acc_d   = {{WIDTH{1'b0}}, bus.a};
                end else begin
                    state_d  = DONE;
                    result_d = bus.alucontrol == 4'b0011 ? '1 : alu_y;
                    hi_d     = bus.alucontrol == 4'b0011 ? bus.a : '0;
                    err_d    = bus.alucontrol == 4'b0011 || bus.alucontrol == 4'b1111;
                end
            end
            MUL, DIV: begin
                acc_d = state_q == MUL ? mul_nx : div_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == (SW+1)'(1)) begin
                    state_d  = DONE;
                    result_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE && state_q != DONE) zero_d = result_d == '0;
    end
    // status outputs decoded from state, results from registers
    always_comb begin
        bus.busy   = state_q != IDLE;
        bus.done   = state_q == DONE;
        bus.result = result_q;
        bus.hi     = hi_q;
        bus.err    = err_q;
        bus.zero   = zero_q;
    end
`ifdef ALUEXEC_OVF_EN
    logic ovf_q, ovf_d;
    // overflow flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end
    // overflow computed at accept for add/sub, cleared by any other accepted start
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && bus.start)
            ovf_d = bus.alucontrol == 4'b0000 ? (bus.a[WIDTH-1] == bus.b[WIDTH-1] && alu_y[WIDTH-1] != bus.a[WIDTH-1]) :
                    bus.alucontrol == 4'b0001 ? (bus.a[WIDTH-1] != bus.b[WIDTH-1] && alu_y[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Multi-cycle execution unit: the consumer of the 4-bit alucontrol code produced by the ALU decoder.
- Logic/shift/compare/add/sub ops complete in 1 cycle.
- mult (shift-add) and div (restoring) iterate one bit per cycle.
- Sits in the EX stage; the controller stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request: latch a, b, alucontrol this cycle
alucontrol  input  4  operation code (table below)
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt/imm); shift amount = b[log2(WIDTH)-1:0]
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: result/hi/err valid
result  output  WIDTH  primary result (product low half / quotient)
hi  output  WIDTH  product high half / remainder; 0 for other ops
err  output  1  set with done: divide-by-zero or illegal code
zero  output  1  result == 0, valid with done
ovf  output  1  signed overflow (optional feature)

Behaviour:
- Codes:
  - 0000 add; 0001 sub; 0010 mult (unsigned); 0011 div (unsigned)
  - 0100 sl (logical left); 0101 sr (logical right)
  - 0110 and; 0111 or; 1000 xor; 1001 nor
  - 1010 jr (result = a); 1011 nand; 1100 not (result = ~a)
  - 1101 slt (signed a<b -> 1 else 0); 1110 sgt (signed a>b -> 1 else 0)
  - 1111 illegal
- Reset (async, reset low): state IDLE; busy=0, done=0, result=0, hi=0, err=0, zero=0, ovf=0; iteration counter=0.
- FSM states IDLE, MUL, DIV, DONE.
- IDLE: start=1 latches a, b, alucontrol.
  - Single-cycle ops: go to DONE, writing result.
  - 0010 -> MUL, counter=WIDTH.
  - 0011 with b!=0 -> DIV, counter=WIDTH.
  - 0011 with b==0 -> DONE, result={WIDTH{1}}, hi=a, err=1.
  - 1111 -> DONE, result=0, err=1.
- MUL: each cycle, if multiplier LSB then add multiplicand into the upper accumulator; shift the 2*WIDTH accumulator right. Counter decrements; at 0 go to DONE with {hi,result} = full 2*WIDTH product.
- DIV: restoring, one quotient bit per cycle, MSB first; at counter 0 go to DONE with result=quotient, hi=remainder.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in MUL, DIV, DONE; busy=0 in IDLE.
- Latency from the start cycle to the done pulse: 1 cycle for single-cycle ops, err cases and div-by-zero; WIDTH+1 cycles for mult and div.
- result/hi/err/zero hold their values after done until the next accepted start.
- start while busy=1 is ignored; no queueing.
- start in the DONE cycle is ignored; the controller must wait for busy=0.
- add/sub wrap modulo 2^WIDTH.
- Shifts by 0 return a unchanged; shift amount uses only the low log2(WIDTH) bits of b.
- hi=0 for all ops except mult/div.
- Operands are latched at start; changes on a/b during MUL/DIV have no effect.
- reset asserted mid-operation aborts immediately: all outputs return to reset values, and no done is emitted.

Optional Feature:
- Macro ALUEXEC_OVF_EN.
- Defined: ovf is set with done for add when both operands have the same sign and the result sign differs, and for sub when the operand signs differ and the result sign differs from a; otherwise 0. ovf is cleared at the next accepted start.
- Undefined: ovf is tied 0 and no overflow logic is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset low mid-MUL (a=7, b=9, cycle 5) -> busy=0, done never pulses, result=0, hi=0; after release, IDLE.
- start add a=0xFFFFFFFF, b=1 -> done on the next cycle, result=0, zero=1, err=0; with ALUEXEC_OVF_EN, add a=0x7FFFFFFF, b=1 -> ovf=1.
- start mult a=0xFFFFFFFF, b=2 -> busy for 33 cycles, done at cycle 33 with result=0xFFFFFFFE, hi=0x00000001; a second start at cycle 10 is ignored.
- start div a=100, b=7 -> done at cycle 33 with result=14, hi=2; div a=5, b=0 -> done after 1 cycle, result=0xFFFFFFFF, hi=5, err=1.
- slt a=0xFFFFFFFE (-2), b=1 -> 1; sgt same operands -> 0; sl a=1, b=0x00000024 -> result=0x10 (amount 4).
- alucontrol=1111 -> done after 1 cycle, err=1, result=0; a following add 2+3 -> result=5, err=0.
